// File: rtl/top_k_tracker.sv
// top_k_tracker: keeps the K largest samples of a window as a registered, sorted list.
module top_k_tracker #(
    parameter int WIDTH = 8,
    parameter int K = 4,
    parameter int CW = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               clear,
    output logic [K*WIDTH-1:0] topk,
    output logic [K-1:0]       topk_vld,
    output logic [WIDTH-1:0]   kth,
    output logic               kth_valid,
    output logic [CW-1:0]      count
);
    logic [K-1:0] ge, gp, svld, nvld;
    logic [K*WIDTH-1:0] sval, nval;
    logic [CW-1:0] ncount;
    // ge is a thermometer code: slots at or above it keep their value, the first clear slot
    // takes din, and every slot below it takes its upper neighbour's contents.
    always_comb begin
        sval = topk << WIDTH;
        svld = topk_vld << 1;
        for (int i = 0; i < K; i++) ge[i] = topk_vld[i] && (topk[i*WIDTH +: WIDTH] >= din);
        gp = {ge[K-2:0], 1'b1};
        nval = clear ? '0 : topk;
        nvld = clear ? '0 : topk_vld;
        ncount = clear ? '0 : count;
        if (din_valid && clear) begin
            nval[WIDTH-1:0] = din;
            nvld[0] = 1'b1;
            ncount = CW'(1);
        end else if (din_valid) begin
            for (int i = 0; i < K; i++) begin
                if (!ge[i]) begin
                    nval[i*WIDTH +: WIDTH] = gp[i] ? din : sval[i*WIDTH +: WIDTH];
                    nvld[i] = gp[i] | svld[i];
                end
            end
            ncount = (count == CW'(K)) ? count : count + CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            topk <= '0;
            topk_vld <= '0;
            kth <= '0;
            kth_valid <= 1'b0;
            count <= '0;
        end else begin
            topk <= nval;
            topk_vld <= nvld;
            kth <= nvld[K-1] ? nval[(K-1)*WIDTH +: WIDTH] : '0;
            kth_valid <= nvld[K-1];
            count <= ncount;
        end
    end
endmodule

// File: tb/tb_top_k_tracker.sv
// tb_top_k_tracker: directed checks on K=4 and K=2 instances, model-checked random stream on K=8.
module tb_top_k_tracker;
    logic clk = 1'b0, reset = 1'b0, din_valid = 1'b0, clear = 1'b0;
    logic [7:0] din = '0;
    logic [31:0] topk4;
    logic [3:0] vld4;
    logic [7:0] kth4;
    logic kv4;
    logic [2:0] cnt4;
    logic [15:0] topk2;
    logic [1:0] vld2;
    logic [7:0] kth2;
    logic kv2;
    logic [1:0] cnt2;
    logic [63:0] topk8;
    logic [7:0] vld8;
    logic [7:0] kth8;
    logic kv8;
    logic [3:0] cnt8;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    top_k_tracker #(.WIDTH(8), .K(4)) u4 (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .clear(clear), .topk(topk4), .topk_vld(vld4), .kth(kth4), .kth_valid(kv4), .count(cnt4));
    top_k_tracker #(.WIDTH(8), .K(2)) u2 (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .clear(clear), .topk(topk2), .topk_vld(vld2), .kth(kth2), .kth_valid(kv2), .count(cnt2));
    top_k_tracker #(.WIDTH(8), .K(8)) u8 (.clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .clear(clear), .topk(topk8), .topk_vld(vld8), .kth(kth8), .kth_valid(kv8), .count(cnt8));

    task automatic step(input logic [7:0] v, input logic dv, input logic c, input logic r);
        din = v;
        din_valid = dv;
        clear = c;
        reset = r;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step(8'd5, 1'b1, 1'b0, 1'b1);
        checks += 5;
        if (topk4 !== 32'd0) $display("FAIL reset_topk: got %h expected %h", topk4, 32'd0); else passed++;
        if (vld4 !== 4'd0) $display("FAIL reset_vld: got %b expected %b", vld4, 4'd0); else passed++;
        if (kth4 !== 8'd0) $display("FAIL reset_kth: got %0d expected 0", kth4); else passed++;
        if (kv4 !== 1'b0) $display("FAIL reset_kv: got %b expected 0", kv4); else passed++;
        if (cnt4 !== 3'd0) $display("FAIL reset_count: got %0d expected 0", cnt4); else passed++;
    endtask

    task automatic test_insert();
        step(8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd3, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (topk4 !== {8'd0, 8'd0, 8'd0, 8'd3}) $display("FAIL first_topk: got %h expected %h", topk4, {8'd0, 8'd0, 8'd0, 8'd3}); else passed++;
        if (cnt4 !== 3'd1) $display("FAIL first_count: got %0d expected 1", cnt4); else passed++;
        step(8'd9, 1'b1, 1'b0, 1'b0);
        step(8'd1, 1'b1, 1'b0, 1'b0);
        step(8'd7, 1'b1, 1'b0, 1'b0);
        step(8'd9, 1'b1, 1'b0, 1'b0);
        checks += 5;
        if (topk4 !== {8'd3, 8'd7, 8'd9, 8'd9}) $display("FAIL insert_topk: got %h expected %h", topk4, {8'd3, 8'd7, 8'd9, 8'd9}); else passed++;
        if (vld4 !== 4'b1111) $display("FAIL insert_vld: got %b expected 1111", vld4); else passed++;
        if (cnt4 !== 3'd4) $display("FAIL insert_count: got %0d expected 4", cnt4); else passed++;
        if (kth4 !== 8'd3) $display("FAIL insert_kth: got %0d expected 3", kth4); else passed++;
        if (kv4 !== 1'b1) $display("FAIL insert_kv: got %b expected 1", kv4); else passed++;
    endtask

    task automatic test_full();
        step(8'd2, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (topk4 !== {8'd3, 8'd7, 8'd9, 8'd9}) $display("FAIL full_below_topk: got %h expected %h", topk4, {8'd3, 8'd7, 8'd9, 8'd9}); else passed++;
        if (cnt4 !== 3'd4) $display("FAIL full_count_sat: got %0d expected 4", cnt4); else passed++;
        step(8'd8, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (topk4 !== {8'd7, 8'd8, 8'd9, 8'd9}) $display("FAIL full_insert_topk: got %h expected %h", topk4, {8'd7, 8'd8, 8'd9, 8'd9}); else passed++;
        if (kth4 !== 8'd7) $display("FAIL full_insert_kth: got %0d expected 7", kth4); else passed++;
        step(8'd99, 1'b0, 1'b0, 1'b0);
        step(8'd1, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (topk4 !== {8'd7, 8'd8, 8'd9, 8'd9}) $display("FAIL hold_topk: got %h expected %h", topk4, {8'd7, 8'd8, 8'd9, 8'd9}); else passed++;
        if (cnt4 !== 3'd4) $display("FAIL hold_count: got %0d expected 4", cnt4); else passed++;
    endtask

    task automatic test_zero();
        step(8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd0, 1'b1, 1'b0, 1'b0);
        step(8'd0, 1'b1, 1'b0, 1'b0);
        checks += 5;
        if (vld4 !== 4'b0011) $display("FAIL zero_vld: got %b expected 0011", vld4); else passed++;
        if (topk4 !== 32'd0) $display("FAIL zero_topk: got %h expected 0", topk4); else passed++;
        if (kth4 !== 8'd0) $display("FAIL zero_kth: got %0d expected 0", kth4); else passed++;
        if (kv4 !== 1'b0) $display("FAIL zero_kv: got %b expected 0", kv4); else passed++;
        if (cnt4 !== 3'd2) $display("FAIL zero_count: got %0d expected 2", cnt4); else passed++;
    endtask

    task automatic test_clear();
        step(8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd9, 1'b1, 1'b0, 1'b0);
        step(8'd7, 1'b1, 1'b0, 1'b0);
        step(8'd4, 1'b1, 1'b1, 1'b0);
        checks += 3;
        if (topk4 !== {8'd0, 8'd0, 8'd0, 8'd4}) $display("FAIL clear_din_topk: got %h expected %h", topk4, {8'd0, 8'd0, 8'd0, 8'd4}); else passed++;
        if (vld4 !== 4'b0001) $display("FAIL clear_din_vld: got %b expected 0001", vld4); else passed++;
        if (cnt4 !== 3'd1) $display("FAIL clear_din_count: got %0d expected 1", cnt4); else passed++;
        step(8'd6, 1'b0, 1'b1, 1'b0);
        checks += 3;
        if (cnt4 !== 3'd0) $display("FAIL clear_count: got %0d expected 0", cnt4); else passed++;
        if (vld4 !== 4'b0000) $display("FAIL clear_vld: got %b expected 0000", vld4); else passed++;
        if (topk4 !== 32'd0) $display("FAIL clear_topk: got %h expected 0", topk4); else passed++;
    endtask

    task automatic test_back_to_back_k2();
        step(8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd255, 1'b1, 1'b0, 1'b0);
        step(8'd0, 1'b1, 1'b0, 1'b0);
        step(8'd255, 1'b1, 1'b0, 1'b0);
        checks += 4;
        if (topk2 !== {8'd255, 8'd255}) $display("FAIL k2_topk: got %h expected %h", topk2, {8'd255, 8'd255}); else passed++;
        if (kth2 !== 8'd255) $display("FAIL k2_kth: got %0d expected 255", kth2); else passed++;
        if (kv2 !== 1'b1) $display("FAIL k2_kv: got %b expected 1", kv2); else passed++;
        if (cnt2 !== 2'd2) $display("FAIL k2_count: got %0d expected 2", cnt2); else passed++;
        step(8'd10, 1'b1, 1'b0, 1'b1);
        checks += 5;
        if (topk2 !== 16'd0) $display("FAIL k2_reset_topk: got %h expected 0", topk2); else passed++;
        if (vld2 !== 2'd0) $display("FAIL k2_reset_vld: got %b expected 00", vld2); else passed++;
        if (kth2 !== 8'd0) $display("FAIL k2_reset_kth: got %0d expected 0", kth2); else passed++;
        if (kv2 !== 1'b0) $display("FAIL k2_reset_kv: got %b expected 0", kv2); else passed++;
        if (cnt2 !== 2'd0) $display("FAIL k2_reset_count: got %0d expected 0", cnt2); else passed++;
        step(8'd6, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (topk2 !== {8'd0, 8'd6}) $display("FAIL k2_after_reset_topk: got %h expected %h", topk2, {8'd0, 8'd6}); else passed++;
        if (cnt2 !== 2'd1) $display("FAIL k2_after_reset_count: got %0d expected 1", cnt2); else passed++;
    endtask

    task automatic test_random_k8();
        int win[$];
        int s[$];
        logic [63:0] et;
        logic [7:0] ev, ek;
        logic [3:0] ec;
        logic [7:0] v;
        logic dv, c;
        step(8'd0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 1000; n++) begin
            v = 8'($urandom_range(0, 31));
            dv = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 99) < 4);
            step(v, dv, c, 1'b0);
            if (c) win.delete();
            if (dv) win.push_back(int'(v));
            s = win;
            s.rsort();
            et = '0;
            ev = '0;
            for (int r = 0; r < 8; r++) begin
                if (r < s.size()) begin
                    et[r*8 +: 8] = 8'(s[r]);
                    ev[r] = 1'b1;
                end
            end
            ek = ev[7] ? et[63:56] : 8'd0;
            ec = (win.size() > 8) ? 4'd8 : 4'(win.size());
            checks++;
            if (topk8 !== et || vld8 !== ev || kth8 !== ek || kv8 !== ev[7] || cnt8 !== ec)
                $display("FAIL rand_k8[%0d]: got %h/%b/%0d/%b/%0d expected %h/%b/%0d/%b/%0d",
                         n, topk8, vld8, kth8, kv8, cnt8, et, ev, ek, ev[7], ec);
            else passed++;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_insert();
        test_full();
        test_zero();
        test_clear();
        test_back_to_back_k2();
        test_random_k8();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/top_k_tracker.md
TOP_K_TRACKER -- requirements
Module: top_k_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample width in bits, unsigned, legal range 1..32.
REQ-002 SHALL have parameter K, default 4: number of largest samples tracked, legal range 2..16.
REQ-003 SHALL have parameter CW, default $clog2(K+1): width of the count output.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: synchronous reset, active-high.
REQ-006 SHALL have port din  input  WIDTH: sample value.
REQ-007 SHALL have port din_valid  input  1: din is consumed on a rising edge where din_valid=1.
REQ-008 SHALL have port clear  input  1: starts a new observation window.
REQ-009 SHALL have port topk  output  K*WIDTH: registered sorted list; slice [WIDTH-1:0] is rank 0 (largest), slice r is rank r.
REQ-010 SHALL have port topk_vld  output  K: bit r=1 iff rank r holds a sample.
REQ-011 SHALL have port kth  output  WIDTH: K-th largest sample (rank K-1), or 0 when topk_vld[K-1]=0.
REQ-012 SHALL have port kth_valid  output  1: equals topk_vld[K-1].
REQ-013 SHALL have port count  output  CW: samples held in the current window, saturating at K.

Function
REQ-014 SHALL keep K entries (value plus valid bit) sorted non-increasing from rank 0; valid entries contiguous from rank 0.
REQ-015 On an accepted sample, SHALL compute insert position p = number of valid entries with value >= din (ties: new sample ranks below existing equal values).
REQ-016 If p < K, SHALL write din at rank p with valid=1, shift ranks p..K-2 down by one, and discard the old rank K-1.
REQ-017 If p = K (list full, din below every entry), SHALL leave the state unchanged.
REQ-018 SHALL treat invalid slots as empty rather than as value 0, so din=0 is inserted while free slots remain.
REQ-019 Duplicate values SHALL occupy separate ranks (stream 5,5 gives rank0=5, rank1=5).
REQ-020 SHALL increment count on every accepted sample until it reaches K, then hold at K.
REQ-021 Latency SHALL be one cycle: a sample accepted at edge N is visible on all outputs after edge N; back-to-back samples SHALL be accepted every cycle with no stall.
REQ-022 With din_valid=0 and clear=0, SHALL hold all state.
REQ-023 clear=1 with din_valid=0 SHALL invalidate all entries, zero all values, and set count=0 at the next edge.
REQ-024 clear=1 with din_valid=1 SHALL start a new window holding din alone: rank0=din, topk_vld=1, count=1, other ranks invalid and zero.
REQ-025 All outputs SHALL be driven directly from registers, with no combinational path from din to any output.
REQ-026 kth SHALL read 0 whenever kth_valid=0, even when rank K-1 holds stale data.

Reset
REQ-027 reset=1 at a rising edge SHALL clear all values to 0, topk_vld to 0, kth to 0, kth_valid to 0, and count to 0.
REQ-028 reset SHALL take priority over clear and din_valid; a sample presented during reset SHALL be dropped.
REQ-029 Deasserting reset mid-stream SHALL start an empty window; the first accepted sample SHALL land at rank 0.

Verification
REQ-030 K=4, WIDTH=8: after reset, samples 3,9,1,7,9 -> ranks 9,9,7,3; count=4; kth=3; kth_valid=1.
REQ-031 K=4: samples 0,0 after reset -> topk_vld=0011, ranks 0,0; kth=0; kth_valid=0; count=2.
REQ-032 K=4, list full at 9,9,7,3: sample 2 -> no change; sample 8 -> ranks 9,9,8,7.
REQ-033 K=4, list holding 9,7: clear=1 with din_valid=1 and din=4 -> rank0=4, topk_vld=0001, count=1; then clear with din_valid=0 -> count=0 and topk_vld=0000.
REQ-034 K=2, WIDTH=8: samples 255,0,255 on consecutive cycles -> ranks 255,255; kth=255; then reset with din_valid=1 and din=10 -> all outputs 0.
REQ-035 Random stream of 1000 samples with random clears, K=8: after every edge, the outputs SHALL match a reference model that sorts the current window and keeps the top K.
